// File: rtl/ce_stream_decimator_pkg.sv
// ce_stream_decimator_pkg: shared defaults, parameter limits and level-width helper.
package ce_stream_decimator_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int DECIM_MIN  = 1;
    localparam int DECIM_MAX  = 16;
    localparam int DEPTH_MIN  = 2;
    localparam int DEPTH_MAX  = 64;
    localparam int PHASE_W    = $clog2(DECIM_MAX);

    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/ce_stream_decimator_if.sv
// ce_stream_decimator_if: sample input strobe and FWFT output handshake of the decimator.
interface ce_stream_decimator_if
    import ce_stream_decimator_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 8
);
    logic                            i_ce;
    logic signed [DATA_W-1:0]        data_in;
    logic                            i_ready;
    logic                            o_valid;
    logic signed [DATA_W-1:0]        o_data;
    logic [level_w(DEPTH)-1:0]       o_level;
    logic                            o_overflow;

    modport master (output i_ce, data_in, i_ready, input o_valid, o_data, o_level, o_overflow);
    modport slave  (input i_ce, data_in, i_ready, output o_valid, o_data, o_level, o_overflow);
endinterface

// File: rtl/ce_stream_decimator_sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO with occupancy counter and registered status.
module sync_fifo_fwft
    import ce_stream_decimator_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DATA_W-1:0]         din,
    output logic [DATA_W-1:0]         dout,
    output logic [level_w(DEPTH)-1:0] level,
    output logic                      full,
    output logic                      empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [LW-1:0]     level_q, level_d;
    logic              wr_en, rd_en;

    assign empty = level_q == '0;
    assign full  = level_q == LW'(DEPTH);
    // A push into a full FIFO is only accepted when the same edge frees a slot.
    assign rd_en   = pop && !empty;
    assign wr_en   = push && (!full || rd_en);
    assign level_d = level_q + LW'(wr_en) - LW'(rd_en);
    assign level   = level_q;
    assign dout    = empty ? '0 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_en ? wr_q + 1'b1 : wr_q;
            rd_q    <= rd_en ? rd_q + 1'b1 : rd_q;
            level_q <= level_d;
        end
    end
endmodule

// File: rtl/ce_stream_decimator.sv
// ce_stream_decimator: keeps every DECIM-th strobed sample and queues it in an FWFT FIFO.
module ce_stream_decimator
    import ce_stream_decimator_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DECIM  = 2,
    parameter int DEPTH  = 8
) (
    input logic              clk,
    input logic              reset_n,
    ce_stream_decimator_if.slave s
);
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               overflow_q, overflow_d;
    logic               push, pop, full, empty;

    assign push = s.i_ce && phase_q == '0;
    assign pop  = s.o_valid && s.i_ready;

    always_comb begin
        phase_d    = !s.i_ce ? phase_q : phase_q == PHASE_W'(DECIM - 1) ? '0 : phase_q + 1'b1;
        overflow_d = overflow_q || (push && full && !pop);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo_fwft #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (push),
        .pop    (pop),
        .din    (s.data_in),
        .dout   (s.o_data),
        .level  (s.o_level),
        .full   (full),
        .empty  (empty)
    );

    assign s.o_valid    = !empty;
    assign s.o_overflow = overflow_q;
endmodule
